// File: rtl/id_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl_pkg
// Shared RV32I ISA definitions for the decode stage:
//   - XLEN and the base opcode constants
//   - instruction field bit positions (rd, rs1, rs2)
//   - immediate-format classification used by imm_gen and the decode logic
// -----------------------------------------------------------------------------
package id_stage_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 7;
    localparam int REG_W    = 5;

    // Register field positions inside the instruction word
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_U_LUI    = 7'b0110111;
    localparam opcode_t OP_U_AUIPC  = 7'b0010111;
    localparam opcode_t OP_J_JAL    = 7'b1101111;
    localparam opcode_t OP_J_JALR   = 7'b1100111;
    localparam opcode_t OP_B_TYPE   = 7'b1100011;
    localparam opcode_t OP_IMM_LOAD = 7'b0000011;
    localparam opcode_t OP_S_TYPE   = 7'b0100011;
    localparam opcode_t OP_IMM      = 7'b0010011;
    localparam opcode_t OP_R_TYPE   = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    // Immediate format carried by an opcode; R-type and unknown opcodes have none
    function automatic imm_fmt_e imm_format(input opcode_t op);
        case (op)
            OP_IMM, OP_IMM_LOAD, OP_J_JALR: return FMT_I;
            OP_S_TYPE:                      return FMT_S;
            OP_B_TYPE:                      return FMT_B;
            OP_U_LUI, OP_U_AUIPC:           return FMT_U;
            OP_J_JAL:                       return FMT_J;
            default:                        return FMT_NONE;
        endcase
    endfunction

    // Every supported opcode already ends in 2'b11, so the full 7-bit match
    // also rejects compressed/reserved encodings
    function automatic logic is_supported(input opcode_t op);
        return (imm_format(op) != FMT_NONE) || (op == OP_R_TYPE);
    endfunction

endpackage

// File: rtl/id_stage_ctrl_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate generator. All formats sign-extend from
// instr[31]; opcodes without an immediate (or unsupported ones) give zero.
// Ports:
//   instr  in  XLEN  instruction word
//   imm    out XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import id_stage_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_format(instr[OPCODE_W-1:0]))
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl
// RV32I decode-stage controller: holds the ID->EX pipeline register behind a
// valid/ready handshake, registers the immediate and register fields, enforces
// the one-bubble load-use interlock, honours flush, and counts bubble cycles.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   flush                        kill held and incoming instruction
//   in_valid/in_ready            fetch-side handshake
//   in_instr, in_pc              incoming instruction and PC
//   out_valid/out_ready          execute-side handshake
//   out_instr, out_pc, out_imm   registered instruction, PC, immediate
//   out_rs1, out_rs2, out_rd     registered register fields
//   out_illegal                  registered unsupported-opcode flag
//   stall_count                  saturating load-use bubble counter
// -----------------------------------------------------------------------------
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int XLEN  = id_stage_ctrl_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_count
);

    opcode_t          in_op;
    opcode_t          held_op;
    logic [REG_W-1:0] in_rs1;
    logic [REG_W-1:0] in_rs2;
    logic [REG_W-1:0] in_rd;
    logic [XLEN-1:0]  imm_next;
    logic             in_illegal;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             hazard;
    logic             capture;
    logic             bubble;

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm_next)
    );

    assign in_op      = in_instr[OPCODE_W-1:0];
    assign held_op    = out_instr[OPCODE_W-1:0];
    assign in_rs1     = in_instr[RS1_LSB +: REG_W];
    assign in_rs2     = in_instr[RS2_LSB +: REG_W];
    assign in_rd      = in_instr[RD_LSB +: REG_W];
    assign in_illegal = !is_supported(in_op) || (in_instr[1:0] != 2'b11);

    always_comb begin
        uses_rs1 = is_supported(in_op) &&
                   !(in_op inside {OP_U_LUI, OP_U_AUIPC, OP_J_JAL});
        uses_rs2 = in_op inside {OP_B_TYPE, OP_S_TYPE, OP_R_TYPE};
    end

    // A held load whose result the incoming instruction reads; x0 never hazards
    assign hazard = out_valid && (held_op == OP_IMM_LOAD) && (out_rd != '0) &&
                    in_valid &&
                    ((uses_rs1 && (in_rs1 == out_rd)) ||
                     (uses_rs2 && (in_rs2 == out_rd)));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;
    // Load leaves while its dependent is refused: exactly one empty slot
    assign bubble   = !flush && hazard && out_ready;

    // Flush beats capture; a refused dependent under out_ready drains the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_imm     <= imm_next;
            out_rs1     <= in_rs1;
            out_rs2     <= in_rs2;
            out_rd      <= in_rd;
            out_illegal <= in_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (bubble && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl. Two instances share the stimulus: one with
// a 2-bit counter to reach saturation quickly, one with the default width.
// A transaction-level model predicts every output each cycle; literal checks
// pin hand-computed values at key points.
module tb_id_stage_ctrl;
    import id_stage_ctrl_pkg::*;

    localparam int NW = 2;
    localparam int WW = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr  = '0;
    logic [31:0] in_pc     = '0;

    logic          n_in_ready, n_out_valid, n_out_illegal;
    logic [31:0]   n_out_instr, n_out_pc, n_out_imm;
    logic [4:0]    n_out_rs1, n_out_rs2, n_out_rd;
    logic [NW-1:0] n_stall;

    logic          w_in_ready, w_out_valid, w_out_illegal;
    logic [31:0]   w_out_instr, w_out_pc, w_out_imm;
    logic [4:0]    w_out_rs1, w_out_rs2, w_out_rd;
    logic [WW-1:0] w_stall;

    int checks   = 0;
    int failures = 0;
    logic seen_ready;

    // transaction-level model state
    bit          m_valid  = 1'b0;
    logic [31:0] m_instr  = '0;
    logic [31:0] m_pc     = '0;
    int          m_stalls = 0;
    bit          m_haz, m_rdy;

    always #5 clk = ~clk;

    id_stage_ctrl #(.XLEN(32), .CNT_W(NW)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_instr(n_out_instr), .out_pc(n_out_pc), .out_imm(n_out_imm),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd(n_out_rd),
        .out_illegal(n_out_illegal), .stall_count(n_stall)
    );

    id_stage_ctrl #(.XLEN(32), .CNT_W(WW)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .out_imm(w_out_imm),
        .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
        .out_illegal(w_out_illegal), .stall_count(w_stall)
    );

    function automatic bit legal(input logic [31:0] w);
        return (w[1:0] == 2'b11) &&
               (w[6:0] inside {OP_U_LUI, OP_U_AUIPC, OP_J_JAL, OP_J_JALR, OP_B_TYPE,
                               OP_IMM_LOAD, OP_S_TYPE, OP_IMM, OP_R_TYPE});
    endfunction

    // Immediate value built arithmetically from weighted bit fields
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [31:0] v;
        v = 32'h0;
        case (w[6:0])
            OP_IMM, OP_IMM_LOAD, OP_J_JALR: v = 32'($signed(w) >>> 20);
            OP_S_TYPE: v = 32'(($signed(w) >>> 25) <<< 5) | 32'(w[11:7]);
            OP_B_TYPE: v = (w[31] ? 32'hFFFFF000 : 32'h0) + (32'(w[7]) << 11) +
                           (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
            OP_U_LUI, OP_U_AUIPC: v = w & 32'hFFFFF000;
            OP_J_JAL:  v = (w[31] ? 32'hFFF00000 : 32'h0) + (32'(w[19:12]) << 12) +
                           (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
            default:   v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        case (w[6:0])
            OP_J_JALR, OP_IMM_LOAD, OP_IMM:   return w[19:15] == r;
            OP_B_TYPE, OP_S_TYPE, OP_R_TYPE:  return (w[19:15] == r) || (w[24:20] == r);
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic bit model_hazard();
        return m_valid && (m_instr[6:0] == OP_IMM_LOAD) && (m_instr[11:7] != 5'd0) &&
               in_valid && reads_reg(in_instr, m_instr[11:7]);
    endfunction

    function automatic bit model_ready();
        return !flush && !model_hazard() && (!m_valid || out_ready);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_instr  = '0;
            m_pc     = '0;
            m_stalls = 0;
        end else begin
            m_haz = model_hazard();
            m_rdy = model_ready();
            if (!flush && m_haz && out_ready) m_stalls++;
            if (flush)                     m_valid = 1'b0;
            else if (in_valid && m_rdy) begin
                m_valid = 1'b1;
                m_instr = in_instr;
                m_pc    = in_pc;
            end else if (out_ready)        m_valid = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic rdy, input logic vld,
                            input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic ill, input logic [31:0] cnt, input int cnt_max);
        checkOutput({tag, "_in_ready"}, 32'(rdy), 32'(model_ready()));
        checkOutput({tag, "_out_valid"}, 32'(vld), 32'(m_valid));
        if (m_valid) begin
            checkOutput({tag, "_out_instr"}, instr, m_instr);
            checkOutput({tag, "_out_pc"}, pc, m_pc);
            checkOutput({tag, "_out_imm"}, imm, ref_imm(m_instr));
            checkOutput({tag, "_out_rs1"}, 32'(rs1), 32'(m_instr[19:15]));
            checkOutput({tag, "_out_rs2"}, 32'(rs2), 32'(m_instr[24:20]));
            checkOutput({tag, "_out_rd"}, 32'(rd), 32'(m_instr[11:7]));
            checkOutput({tag, "_out_illegal"}, 32'(ill), 32'(!legal(m_instr)));
        end
        checkOutput({tag, "_stall_count"}, cnt, 32'(sat(m_stalls, cnt_max)));
    endtask

    always @(negedge clk) begin
        checkAll("n", n_in_ready, n_out_valid, n_out_instr, n_out_pc, n_out_imm,
                 n_out_rs1, n_out_rs2, n_out_rd, n_out_illegal, 32'(n_stall), 3);
        checkAll("w", w_in_ready, w_out_valid, w_out_instr, w_out_pc, w_out_imm,
                 w_out_rs1, w_out_rs2, w_out_rd, w_out_illegal, 32'(w_stall), 65535);
    end

    // Drive one cycle of inputs; seen_ready captures in_ready before the edge
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        seen_ready = n_in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(n_out_valid), 32'h0);
        checkOutput("reset_out_instr", n_out_instr, 32'h0);
        checkOutput("reset_out_imm", n_out_imm, 32'h0);
        checkOutput("reset_stall", 32'(w_stall), 32'h0);
        rst_n = 1'b1;

        // ADDI x1,x0,5
        applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        checkOutput("addi_valid", 32'(n_out_valid), 32'h1);
        checkOutput("addi_imm", n_out_imm, 32'h00000005);
        checkOutput("addi_rd", 32'(n_out_rd), 32'd1);
        checkOutput("addi_illegal", 32'(n_out_illegal), 32'h0);
        // SW x2,-8(x1)
        applyStimulus(1'b1, 32'hFE20AC23, 32'h104, 1'b1, 1'b0);
        checkOutput("sw_imm", n_out_imm, 32'hFFFFFFF8);
        checkOutput("sw_rs1", 32'(n_out_rs1), 32'd1);
        checkOutput("sw_rs2", 32'(n_out_rs2), 32'd2);
        // LW x5,0(x1) then dependent ADD x6,x5,x5
        applyStimulus(1'b1, 32'h0000A283, 32'h108, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00528333, 32'h10C, 1'b1, 1'b0);
        checkOutput("loaduse_ready", 32'(seen_ready), 32'h0);
        checkOutput("loaduse_bubble", 32'(n_out_valid), 32'h0);
        checkOutput("loaduse_stall", 32'(w_stall), 32'd1);
        applyStimulus(1'b1, 32'h00528333, 32'h10C, 1'b1, 1'b0);
        checkOutput("loaduse_accept", 32'(seen_ready), 32'h1);
        checkOutput("loaduse_add", n_out_instr, 32'h00528333);
        // LW x0 then ADD x6,x0,x0: no interlock
        applyStimulus(1'b1, 32'h0000A003, 32'h110, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00000333, 32'h114, 1'b1, 1'b0);
        checkOutput("x0_ready", 32'(seen_ready), 32'h1);
        checkOutput("x0_stall", 32'(w_stall), 32'd1);
        // LW x7 then LUI x7,0x12345: LUI reads nothing
        applyStimulus(1'b1, 32'h0000A383, 32'h118, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h123453B7, 32'h11C, 1'b1, 1'b0);
        checkOutput("lui_ready", 32'(seen_ready), 32'h1);
        checkOutput("lui_imm", n_out_imm, 32'h12345000);
        // BEQ x1,x2,-4 and JAL x1,+2048
        applyStimulus(1'b1, 32'hFE208EE3, 32'h120, 1'b1, 1'b0);
        checkOutput("beq_imm", n_out_imm, 32'hFFFFFFFC);
        applyStimulus(1'b1, 32'h001000EF, 32'h124, 1'b1, 1'b0);
        checkOutput("jal_imm", n_out_imm, 32'h00000800);
        // Downstream stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h00100113, 32'h128, 1'b0, 1'b0);
            checkOutput("hold_ready", 32'(seen_ready), 32'h0);
            checkOutput("hold_instr", n_out_instr, 32'h001000EF);
            checkOutput("hold_imm", n_out_imm, 32'h00000800);
        end
        // Flush with an incoming word
        applyStimulus(1'b1, 32'h00200193, 32'h12C, 1'b0, 1'b1);
        checkOutput("flush_ready", 32'(seen_ready), 32'h0);
        checkOutput("flush_valid", 32'(n_out_valid), 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_idle_valid", 32'(n_out_valid), 32'h0);
        // Illegal encodings
        applyStimulus(1'b1, 32'h0000007F, 32'h200, 1'b1, 1'b0);
        checkOutput("illegal_flag", 32'(n_out_illegal), 32'h1);
        checkOutput("illegal_imm", n_out_imm, 32'h0);
        applyStimulus(1'b1, 32'h00500090, 32'h204, 1'b1, 1'b0);
        checkOutput("lowbits_illegal", 32'(n_out_illegal), 32'h1);
        checkOutput("lowbits_imm", n_out_imm, 32'h0);
        // Hazard while EX stalls: held, not counted; then hazard under flush
        applyStimulus(1'b1, 32'h0000A283, 32'h208, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00528333, 32'h20C, 1'b0, 1'b0);
        checkOutput("hold_haz_ready", 32'(seen_ready), 32'h0);
        checkOutput("hold_haz_instr", n_out_instr, 32'h0000A283);
        checkOutput("hold_haz_stall", 32'(w_stall), 32'd1);
        applyStimulus(1'b1, 32'h00528333, 32'h20C, 1'b1, 1'b1);
        checkOutput("flush_haz_valid", 32'(n_out_valid), 32'h0);
        checkOutput("flush_haz_stall", 32'(w_stall), 32'd1);
        // Four more interlocks: narrow counter saturates at 3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000A283, 32'h300, 1'b1, 1'b0);
            applyStimulus(1'b1, 32'h00528333, 32'h304, 1'b1, 1'b0);
            applyStimulus(1'b1, 32'h00528333, 32'h304, 1'b1, 1'b0);
        end
        checkOutput("sat_narrow", 32'(n_stall), 32'd3);
        checkOutput("sat_wide", 32'(w_stall), 32'd5);
        // Reset asserted in the middle of a hold
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("prereset_valid", 32'(n_out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(n_out_valid), 32'h0);
        checkOutput("midreset_stall", 32'(n_stall), 32'h0);
        checkOutput("midreset_imm", n_out_imm, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 32'h00500093, 32'h400, 1'b1, 1'b0);
        checkOutput("postreset_valid", 32'(n_out_valid), 32'h1);
        checkOutput("postreset_pc", n_out_pc, 32'h400);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
